// File: rtl/dv_checkpoint_monitor.sv
// Checkpoint monitor: synchronizes and filters a firmware status bus and tracks an ordered list of expected codes under a timeout.
// Optional macro CHK_MON_STRICT_EN: any unexpected nonzero stable code in WAIT fails the run.
module dv_checkpoint_monitor #(
    parameter int CHK_W      = 16,
    parameter int NUM_CHK    = 4,
    parameter int STG_W      = 2,
    parameter int TMO_W      = 24,
    parameter int STABLE_CYC = 3
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start_i,
    input  logic [TMO_W-1:0]         tmo_cyc_i,
    input  logic [NUM_CHK*CHK_W-1:0] exp_codes_i,
    input  logic [CHK_W-1:0]         chk_bits_i,
    output logic                     busy_o,
    output logic [STG_W-1:0]         stage_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic [CHK_W-1:0]         last_code_o
);

    localparam int CNT_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PASS, ST_FAIL} state_t;

    state_t             state_q, state_d;
    logic [CHK_W-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, hold_q, hold_d;
    logic [CHK_W-1:0]   last_code_q, last_code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stage_q, stage_d, stage_inc;
    logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
    logic               pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic               changed, stable_evt, code_match, tmo_hit;
    logic [CHK_W-1:0]   exp_cur;
    logic [CHK_W-1:0]   exp_arr [NUM_CHK];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHK; gi++) begin : g_exp
            assign exp_arr[gi] = exp_codes_i[gi*CHK_W +: CHK_W];
        end
    endgenerate

    assign changed = (sync2_q != hold_q);

    // A code fires exactly once, on the cycle its hold count reaches STABLE_CYC.
    generate
        if (STABLE_CYC == 0) begin : g_nofilt
            assign stable_evt = changed;
        end else begin : g_filt
            assign stable_evt = !changed && (cnt_q == CNT_W'(STABLE_CYC - 1));
        end
    endgenerate

    always_comb begin
        sync1_d     = chk_bits_i;
        sync2_d     = sync1_q;
        hold_d      = sync2_q;
        cnt_d       = cnt_q;
        last_code_d = last_code_q;
        if (start_i) begin
            // Saturating the counter discards whatever code is currently being filtered.
            cnt_d = CNT_W'(STABLE_CYC);
        end else if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (stable_evt && !start_i) begin
            last_code_d = sync2_q;
        end
    end

    always_comb begin
        exp_cur = '0;
        for (int k = 0; k < NUM_CHK; k++) begin
            if (stage_q == STG_W'(k)) exp_cur = exp_arr[k];
        end
    end

`ifdef CHK_MON_STRICT_EN
    logic [CHK_W-1:0] prev_code;
    logic             have_prev, code_bad;

    always_comb begin
        prev_code = '0;
        have_prev = 1'b0;
        for (int k = 0; k < NUM_CHK; k++) begin
            if (stage_q == STG_W'(k + 1)) begin
                prev_code = exp_arr[k];
                have_prev = 1'b1;
            end
        end
    end

    // Zero is the idle bus value and the repeat of the last matched code is benign.
    assign code_bad = stable_evt && (sync2_q != exp_cur) && (sync2_q != '0)
                      && !(have_prev && (sync2_q == prev_code));
`endif

    assign stage_inc  = stage_q + 1'b1;
    assign tmo_inc    = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
    assign tmo_hit    = (tmo_cyc_i != '0) && (tmo_inc == tmo_cyc_i);
    assign code_match = stable_evt && (sync2_q == exp_cur);

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        tmo_d     = tmo_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        if (start_i) begin
            state_d   = ST_WAIT;
            stage_d   = '0;
            tmo_d     = '0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == ST_WAIT) begin
            tmo_d = tmo_inc;
            if (code_match && (stage_inc == STG_W'(NUM_CHK))) begin
                stage_d = stage_inc;
                state_d = ST_PASS;
                pass_d  = 1'b1;
            end else begin
                if (code_match) stage_d = stage_inc;
                if (tmo_hit) begin
                    state_d   = ST_FAIL;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end
`ifdef CHK_MON_STRICT_EN
                else if (code_bad) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            last_code_q <= '0;
            stage_q     <= '0;
            tmo_q       <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            last_code_q <= last_code_d;
            stage_q     <= stage_d;
            tmo_q       <= tmo_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy_o      = (state_q == ST_WAIT);
    assign stage_o     = stage_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign last_code_o = last_code_q;

endmodule

// File: tb/tb_dv_checkpoint_monitor.sv
// Directed bench for dv_checkpoint_monitor: two-code sequence, filter latency, timeout, restart and reset.
module tb_dv_checkpoint_monitor;

    localparam int CHK_W = 16;
    localparam int NUM_CHK = 2;
    localparam int STG_W = 2;
    localparam int TMO_W = 24;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [TMO_W-1:0]         tmo_cyc;
    logic [NUM_CHK*CHK_W-1:0] exp_codes;
    logic [CHK_W-1:0]         chk_bits;
    logic                     busy;
    logic [STG_W-1:0]         stage;
    logic                     pass_f, fail_f, timeout_f;
    logic [CHK_W-1:0]         last_code;

    int tests = 0;
    int fails = 0;

    dv_checkpoint_monitor #(
        .CHK_W(CHK_W), .NUM_CHK(NUM_CHK), .STG_W(STG_W), .TMO_W(TMO_W), .STABLE_CYC(3)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .tmo_cyc_i(tmo_cyc),
        .exp_codes_i(exp_codes), .chk_bits_i(chk_bits), .busy_o(busy), .stage_o(stage),
        .pass_o(pass_f), .fail_o(fail_f), .timeout_o(timeout_f), .last_code_o(last_code)
    );

    always #5 clk = ~clk;

    // Each step ends 1 ns after a rising edge, so samples and drives are clear of the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        chk_bits = 16'h0000;
        step(10);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tmo_cyc = '0; chk_bits = '0;
        exp_codes = {16'hAB6A, 16'hAB60};
        step(3);
        $display("[TB] reset state");
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_pass", 32'(pass_f), 32'd0);
        chk("rst_fail", 32'(fail_f), 32'd0);
        chk("rst_timeout", 32'(timeout_f), 32'd0);
        chk("rst_last", 32'(last_code), 32'h0);
        rst = 1'b0;
        step(8);

        $display("[TB] pass sequence AB60 -> AB6A");
        tmo_cyc = 24'd30000;
        start_pulse();
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_stage", 32'(stage), 32'd0);
        chk_bits = 16'hAB60;
        step(5);
        chk("s1_early", 32'(stage), 32'd0);
        step(1);
        chk("s1_on_time", 32'(stage), 32'd1);
        chk("s1_last", 32'(last_code), 32'hAB60);
        chk_bits = 16'hAB6A;
        step(5);
        chk("pass_early", 32'(pass_f), 32'd0);
        step(1);
        chk("pass_on_time", 32'(pass_f), 32'd1);
        chk("pass_busy", 32'(busy), 32'd0);
        chk("pass_fail", 32'(fail_f), 32'd0);
        chk("pass_stage", 32'(stage), 32'd2);
        chk("pass_last", 32'(last_code), 32'hAB6A);
        settle();
        chk("pass_hold", 32'(pass_f), 32'd1);

        $display("[TB] timeout after 30000 cycles");
        start_pulse();
        chk_bits = 16'hAB60;
        step(29999);
        chk("tmo_early", 32'(fail_f), 32'd0);
        step(1);
        chk("tmo_fail", 32'(fail_f), 32'd1);
        chk("tmo_flag", 32'(timeout_f), 32'd1);
        chk("tmo_stage", 32'(stage), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        settle();

        $display("[TB] 2-cycle glitch is filtered");
        start_pulse();
        chk_bits = 16'hAB60;
        step(6);
        chk("gl_s1", 32'(stage), 32'd1);
        chk_bits = 16'hAB6A;
        step(2);
        chk_bits = 16'h0000;
        step(12);
        chk("gl_stage", 32'(stage), 32'd1);
        chk("gl_pass", 32'(pass_f), 32'd0);
        chk("gl_fail", 32'(fail_f), 32'd0);
        chk("gl_last", 32'(last_code), 32'h0);
        chk_bits = 16'hAB6A;
        step(6);
        chk("gl_then_pass", 32'(pass_f), 32'd1);
        settle();

        $display("[TB] final match on the timeout cycle");
        tmo_cyc = 24'd12;
        start_pulse();
        chk_bits = 16'hAB60;
        step(6);
        chk_bits = 16'hAB6A;
        step(6);
        chk("tie_pass", 32'(pass_f), 32'd1);
        chk("tie_fail", 32'(fail_f), 32'd0);
        chk("tie_timeout", 32'(timeout_f), 32'd0);
        settle();

        $display("[TB] timeout one cycle before final match");
        tmo_cyc = 24'd11;
        start_pulse();
        chk_bits = 16'hAB60;
        step(6);
        chk_bits = 16'hAB6A;
        step(5);
        chk("tm1_fail", 32'(fail_f), 32'd1);
        chk("tm1_timeout", 32'(timeout_f), 32'd1);
        chk("tm1_stage", 32'(stage), 32'd1);
        step(1);
        chk("tm1_no_pass", 32'(pass_f), 32'd0);
        settle();

        $display("[TB] restart mid-WAIT");
        tmo_cyc = 24'd20;
        start_pulse();
        chk_bits = 16'hAB60;
        step(6);
        chk("rs_s1", 32'(stage), 32'd1);
        step(4);
        start_pulse();
        chk("rs_stage0", 32'(stage), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        step(18);
        chk("rs_no_old_tmo", 32'(fail_f), 32'd0);
        step(1);
        chk("rs_tmo_early", 32'(fail_f), 32'd0);
        chk("rs_no_retrigger", 32'(stage), 32'd0);
        step(1);
        chk("rs_tmo_fail", 32'(fail_f), 32'd1);
        chk("rs_tmo_flag", 32'(timeout_f), 32'd1);
        settle();

        $display("[TB] asynchronous reset mid-WAIT");
        tmo_cyc = 24'd30000;
        start_pulse();
        chk_bits = 16'hAB60;
        step(6);
        chk_bits = 16'hAB6A;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_stage", 32'(stage), 32'd0);
        chk("ar_last", 32'(last_code), 32'h0);
        chk("ar_pass", 32'(pass_f), 32'd0);
        step(1);
        rst = 1'b0;
        step(10);
        chk("ar_idle", 32'(busy), 32'd0);
        chk("ar_no_pass", 32'(pass_f), 32'd0);
        settle();

        $display("[TB] unexpected stable code 1234");
        start_pulse();
        chk_bits = 16'hAB60;
        step(6);
        chk_bits = 16'h1234;
        step(6);
        chk("ill_last", 32'(last_code), 32'h1234);
        chk("ill_stage", 32'(stage), 32'd1);
`ifdef CHK_MON_STRICT_EN
        chk("ill_fail", 32'(fail_f), 32'd1);
        chk("ill_timeout", 32'(timeout_f), 32'd0);
        chk("ill_busy", 32'(busy), 32'd0);
`else
        chk("ill_ignored", 32'(fail_f), 32'd0);
        chk("ill_busy", 32'(busy), 32'd1);
        chk_bits = 16'hAB6A;
        step(6);
        chk("ill_then_pass", 32'(pass_f), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
